// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and defaults for the FFT output reorder buffer
// Contents: bank_state_e (per-bank ping-pong state), DEF_WIDTH, DEF_ADDR_W, MAX_POINTS.
package fft_pkg;

    localparam int DEF_WIDTH  = 18;
    localparam int DEF_ADDR_W = 11;
    localparam int MAX_POINTS = 2 ** DEF_ADDR_W;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/fft_reorder_buf_if.sv
// rtl/fft_reorder_buf_if.sv - sample stream bundle for the reorder buffer
// Signals: di_en/di_re/di_im (input stream, no backpressure),
//          do_ready/do_valid/do_re/do_im/address/Finish (output stream).
// Modports: master = producer/consumer side, slave = reorder buffer side.
interface fft_reorder_buf_if
    import fft_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              di_en;
    logic [WIDTH-1:0]  di_re;
    logic [WIDTH-1:0]  di_im;
    logic              do_ready;
    logic              do_valid;
    logic [WIDTH-1:0]  do_re;
    logic [WIDTH-1:0]  do_im;
    logic [ADDR_W-1:0] address;
    logic              Finish;

    modport master (
        output di_en, di_re, di_im, do_ready,
        input  do_valid, do_re, do_im, address, Finish
    );

    modport slave (
        input  di_en, di_re, di_im, do_ready,
        output do_valid, do_re, do_im, address, Finish
    );
endinterface

// File: rtl/fft_reorder_wr_addr.sv
// rtl/fft_reorder_wr_addr.sv - strided write address generator (addr = x + c*N2)
// Ports: clk, rst (async active-low), cfg_load/cfg_n1/cfg_n2 (config request),
//        adv (one sample written), wr_addr, wr_last (frame's final sample),
//        points (latched N1*N2), cfg_ok (config nonzero), cfg_acc (config taken),
//        cfg_err (sticky reject), cnt_busy (counters mid-frame).
module fft_reorder_wr_addr #(
    parameter int ADDR_W = 11,
    parameter int N1_W   = 9,
    parameter int N2_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [N1_W-1:0]   cfg_n1,
    input  logic [N2_W-1:0]   cfg_n2,
    input  logic              adv,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_last,
    output logic [ADDR_W:0]   points,
    output logic              cfg_ok,
    output logic              cfg_acc,
    output logic              cfg_err,
    output logic              cnt_busy
);
    localparam int PW = N1_W + N2_W;

    logic [N1_W-1:0]   n1, c;
    logic [N2_W-1:0]   n2, x;
    logic [ADDR_W-1:0] base;
    logic [PW-1:0]     prod;
    logic              at_start, bad, c_wrap;

    always_comb begin
        prod     = PW'(cfg_n1) * PW'(cfg_n2);
        bad      = (prod == '0) || (prod > PW'(2 ** ADDR_W));
        at_start = (c == '0) && (x == '0);
        cfg_acc  = cfg_load && at_start && !bad;
        cfg_ok   = (n1 != '0);
        c_wrap   = (c == n1 - N1_W'(1));
        wr_last  = c_wrap && (x == n2 - N2_W'(1));
        wr_addr  = base + ADDR_W'(x);
        cnt_busy = !at_start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n1      <= '0;
            n2      <= '0;
            points  <= '0;
            c       <= '0;
            x       <= '0;
            base    <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_load && !cfg_acc)
                cfg_err <= 1'b1;
            if (cfg_acc) begin
                n1     <= cfg_n1;
                n2     <= cfg_n2;
                points <= (ADDR_W + 1)'(prod);
            end
            if (adv) begin
                if (wr_last) begin
                    c    <= '0;
                    x    <= '0;
                    base <= '0;
                end else if (c_wrap) begin
                    c    <= '0;
                    base <= '0;
                    x    <= x + N2_W'(1);
                end else begin
                    c    <= c + N1_W'(1);
                    base <= base + ADDR_W'(n2);
                end
            end
        end
    end
endmodule

// File: rtl/fft_reorder_buf.sv
// rtl/fft_reorder_buf.sv - ping-pong reorder buffer: digit-reversed in, natural order out
// Ports: clk, rst (async active-low), cfg_load/cfg_n1/cfg_n2 (frame config),
//        s (fft_reorder_buf_if.slave sample streams), Busy, cfg_err, ovf.
// Option: FFT_REORDER_SCALE_EN adds cfg_shift[1:0] and rounded, saturating output scaling.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N1_W   = 9,
    parameter int N2_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_load,
    input  logic [N1_W-1:0] cfg_n1,
    input  logic [N2_W-1:0] cfg_n2,
`ifdef FFT_REORDER_SCALE_EN
    input  logic [1:0]      cfg_shift,
`endif
    fft_reorder_buf_if.slave s,
    output logic            Busy,
    output logic            cfg_err,
    output logic            ovf
);
    bank_state_e       bank_st  [2];
    bank_state_e       bank_nxt [2];
    logic [ADDR_W:0]   bank_p   [2];
    logic [2*WIDTH-1:0] mem [2**(ADDR_W+1)];

    logic              w_sel, ri, rr;
    logic [ADDR_W-1:0] wr_addr, rd_addr, s1_addr;
    logic [ADDR_W:0]   points, p_last;
    logic [2*WIDTH-1:0] s1_data;
    logic              wr_last, cfg_ok, cfg_acc, cnt_busy;
    logic              wr_space, wr_en, drop, adv, rd_first, can_issue, issue, issue_last, release_bank;
    logic              s1_valid, s1_last;

    fft_reorder_wr_addr #(.ADDR_W(ADDR_W), .N1_W(N1_W), .N2_W(N2_W)) u_wr_addr (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_n1(cfg_n1), .cfg_n2(cfg_n2),
        .adv(wr_en), .wr_addr(wr_addr), .wr_last(wr_last), .points(points),
        .cfg_ok(cfg_ok), .cfg_acc(cfg_acc), .cfg_err(cfg_err), .cnt_busy(cnt_busy)
    );

`ifdef FFT_REORDER_SCALE_EN
    logic [1:0] shift_q;

    // Round half up; a rounding carry into the sign bit saturates the whole result.
    function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] v, input logic [1:0] sh);
        logic signed [WIDTH:0] sum;
        if (sh == 2'd0)
            return v;
        sum = {v[WIDTH-1], v} + ((WIDTH + 1)'(1) << (sh - 2'd1));
        if (sum[WIDTH] != sum[WIDTH-1])
            return {1'b0, {(WIDTH-1){1'b1}}};
        return WIDTH'(sum >>> sh);
    endfunction
`endif

    // Pipeline and bank control outputs
    always_comb begin
        wr_space     = (bank_st[w_sel] == EMPTY) || (bank_st[w_sel] == FILLING);
        wr_en        = s.di_en && cfg_ok && wr_space;
        drop         = s.di_en && cfg_ok && !wr_space;
        adv          = !s.do_valid || s.do_ready;
        rd_first     = (rd_addr == '0);
        // Address 0 needs a freshly FULL bank; later addresses continue a bank already READING.
        can_issue    = rd_first ? (bank_st[ri] == FULL) : 1'b1;
        issue        = adv && can_issue;
        p_last       = bank_p[ri] - (ADDR_W + 1)'(1);
        issue_last   = ({1'b0, rd_addr} == p_last);
        release_bank = s.do_valid && s.do_ready && s.Finish;
        Busy         = (bank_st[0] != EMPTY) || (bank_st[1] != EMPTY) || cnt_busy;
    end

    // Bank next state: write, issue and release always act on banks in different states.
    always_comb begin
        bank_nxt = bank_st;
        if (wr_en)
            bank_nxt[w_sel] = wr_last ? FULL : FILLING;
        if (issue && rd_first)
            bank_nxt[ri] = READING;
        if (release_bank)
            bank_nxt[rr] = EMPTY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
        end else begin
            bank_st <= bank_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_sel      <= 1'b0;
            ri         <= 1'b0;
            rr         <= 1'b0;
            rd_addr    <= '0;
            bank_p[0]  <= '0;
            bank_p[1]  <= '0;
            ovf        <= 1'b0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_addr    <= '0;
            s.do_valid <= 1'b0;
            s.do_re    <= '0;
            s.do_im    <= '0;
            s.address  <= '0;
            s.Finish   <= 1'b0;
`ifdef FFT_REORDER_SCALE_EN
            shift_q    <= 2'd0;
`endif
        end else begin
`ifdef FFT_REORDER_SCALE_EN
            if (cfg_acc)
                shift_q <= cfg_shift;
`endif
            if (wr_en && wr_last) begin
                bank_p[w_sel] <= points;
                w_sel         <= ~w_sel;
            end
            if (drop)
                ovf <= 1'b1;
            if (issue) begin
                if (issue_last) begin
                    rd_addr <= '0;
                    ri      <= ~ri;
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
            if (release_bank)
                rr <= ~rr;
            if (adv) begin
                s1_valid   <= issue;
                s1_last    <= issue && issue_last;
                s1_addr    <= rd_addr;
                s.do_valid <= s1_valid;
                s.Finish   <= s1_valid && s1_last;
                if (s1_valid) begin
                    s.address <= s1_addr;
`ifdef FFT_REORDER_SCALE_EN
                    s.do_re   <= scale(s1_data[2*WIDTH-1:WIDTH], shift_q);
                    s.do_im   <= scale(s1_data[WIDTH-1:0], shift_q);
`else
                    s.do_re   <= s1_data[2*WIDTH-1:WIDTH];
                    s.do_im   <= s1_data[WIDTH-1:0];
`endif
                end
            end
        end
    end

    // Sample RAM: bank select is the address MSB; read register advances with the pipeline.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{w_sel, wr_addr}] <= {s.di_re, s.di_im};
        if (issue)
            s1_data <= mem[{ri, rd_addr}];
    end
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb/tb_fft_reorder_buf.sv - directed self-checking bench for fft_reorder_buf
module tb_fft_reorder_buf;
    import fft_pkg::*;

    localparam int W  = 18;
    localparam int AW = 11;

    typedef struct {
        logic [W-1:0]  re;
        logic [W-1:0]  im;
        logic [AW-1:0] addr;
        logic          fin;
        int            cyc;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_load = 1'b0;
    logic [8:0] cfg_n1 = '0;
    logic [7:0] cfg_n2 = '0;
    logic       busy, cfg_err, ovf;
`ifdef FFT_REORDER_SCALE_EN
    logic [1:0] cfg_shift = 2'd0;
`endif

    fft_reorder_buf_if #(.WIDTH(W), .ADDR_W(AW)) s();

    fft_reorder_buf #(.WIDTH(W), .ADDR_W(AW), .N1_W(9), .N2_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_n1(cfg_n1), .cfg_n2(cfg_n2),
`ifdef FFT_REORDER_SCALE_EN
        .cfg_shift(cfg_shift),
`endif
        .s(s), .Busy(busy), .cfg_err(cfg_err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_wr = 0;
    int   hold_chk = 0;
    int   hold_bad = 0;
    ent_t log_q [$];
    logic prev_stall = 1'b0;
    logic [2*W+AW:0] prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s.do_valid && s.do_ready)
            log_q.push_back('{s.do_re, s.do_im, s.address, s.Finish, cyc});
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                hold_chk <= hold_chk + 1;
                if ({s.do_re, s.do_im, s.address, s.Finish} !== prev_out)
                    hold_bad <= hold_bad + 1;
            end
            prev_stall <= s.do_valid && !s.do_ready;
            prev_out   <= {s.do_re, s.do_im, s.address, s.Finish};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int n1, input int n2);
        cfg_load = 1'b1;
        cfg_n1   = 9'(n1);
        cfg_n2   = 8'(n2);
        tick();
        cfg_load = 1'b0;
    endtask

    // Twelve consecutive samples base..base+11; optional mid-frame cfg_load at index load_at.
    task automatic send_frame(input int base, input int load_at);
        for (int i = 0; i < 12; i++) begin
            cfg_load = (i == load_at);
            if (i == load_at) begin
                cfg_n1 = 9'd2;
                cfg_n2 = 8'd3;
            end
            s.di_en = 1'b1;
            s.di_re = W'(base + i);
            s.di_im = W'(base + i + 500);
            last_wr = cyc + 1;
            tick();
        end
        s.di_en  = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n);
        int k = 0;
        while (log_q.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(log_q.size() >= n), 32'd1);
    endtask

    // N1=4, N2=3: natural address a holds input sample (a%3)*4 + a/3.
    task automatic chk_frame(input string tag, input int off, input int base);
        ent_t e;
        int   ev;
        for (int a = 0; a < 12; a++) begin
            if (off + a < log_q.size()) begin
                e = log_q[off + a];
            end else begin
                e.re = '1; e.im = '1; e.addr = '1; e.fin = 1'b0; e.cyc = 0;
            end
            ev = base + (a % 3) * 4 + a / 3;
            chk($sformatf("%s.re[%0d]", tag, a), 32'(e.re), 32'(ev));
            chk($sformatf("%s.im[%0d]", tag, a), 32'(e.im), 32'(ev + 500));
            chk($sformatf("%s.addr[%0d]", tag, a), 32'(e.addr), 32'(a));
            chk($sformatf("%s.fin[%0d]", tag, a), 32'(e.fin), 32'(a == 11));
        end
    endtask

    function automatic int fin_count();
        int n = 0;
        foreach (log_q[i]) n += int'(log_q[i].fin);
        return n;
    endfunction

    initial begin
        s.di_en = 1'b0; s.di_re = '0; s.di_im = '0; s.do_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.do_valid", 32'(s.do_valid), 0);
        chk("rst.finish", 32'(s.Finish), 0);
        chk("rst.address", 32'(s.address), 0);
        chk("rst.do_re", 32'(s.do_re), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.cfg_err", 32'(cfg_err), 0);
        chk("rst.ovf", 32'(ovf), 0);
        rst = 1'b1;
        tick();

        // Single 4x3 frame with latency measurement
        load_cfg(4, 3);
        chk("cfg_ok.err", 32'(cfg_err), 0);
        log_q.delete();
        send_frame(0, -1);
        wait_log("single.timeout", 12);
        chk("single.latency", (log_q.size() > 0) ? 32'(log_q[0].cyc - last_wr) : 32'hFFFF, 32'd2);
        chk_frame("single", 0, 0);
        repeat (3) tick();
        chk("single.busy_idle", 32'(busy), 0);

        // Back-to-back frames, continuous output
        log_q.delete();
        send_frame(0, -1);
        send_frame(100, -1);
        wait_log("b2b.timeout", 24);
        chk_frame("b2b0", 0, 0);
        chk_frame("b2b1", 12, 100);
        chk("b2b.contig", (log_q.size() >= 24) ? 32'(log_q[23].cyc - log_q[0].cyc) : 32'hFFFF, 32'd23);
        chk("b2b.fin_cnt", 32'(fin_count()), 32'd2);
        chk("b2b.ovf", 32'(ovf), 0);
        repeat (3) tick();

        // Same frames under toggling do_ready
        log_q.delete();
        fork
            begin
                send_frame(0, -1);
                send_frame(100, -1);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    s.do_ready = (i % 2 == 0);
                    tick();
                end
            end
        join
        s.do_ready = 1'b1;
        wait_log("tog.timeout", 24);
        repeat (4) tick();
        chk("tog.count", 32'(log_q.size()), 32'd24);
        chk_frame("tog0", 0, 0);
        chk_frame("tog1", 12, 100);
        chk("tog.hold_bad", 32'(hold_bad), 0);
        chk("tog.stalls_seen", 32'(hold_chk > 0), 32'd1);
        chk("tog.ovf", 32'(ovf), 0);

        // Three frames against a blocked consumer: the third is dropped
        log_q.delete();
        s.do_ready = 1'b0;
        send_frame(200, -1);
        send_frame(300, -1);
        send_frame(400, -1);
        tick();
        chk("ovf.set", 32'(ovf), 1);
        chk("ovf.no_out", 32'(log_q.size()), 0);
        s.do_ready = 1'b1;
        wait_log("ovf.timeout", 24);
        repeat (5) tick();
        chk("ovf.count", 32'(log_q.size()), 32'd24);
        chk_frame("ovf0", 0, 200);
        chk_frame("ovf1", 12, 300);
        chk("ovf.hold_bad", 32'(hold_bad), 0);
        chk("ovf.busy_idle", 32'(busy), 0);

        // Oversized config is rejected and 4x3 stays in force
        load_cfg(256, 9);
        chk("big.cfg_err", 32'(cfg_err), 1);
        log_q.delete();
        send_frame(500, -1);
        wait_log("big.timeout", 12);
        chk_frame("big", 0, 500);
        repeat (3) tick();

        // Asynchronous reset during sample 5
        for (int i = 0; i < 6; i++) begin
            s.di_en = 1'b1;
            s.di_re = W'(i);
            s.di_im = W'(i);
            if (i == 5) begin
                rst = 1'b0;
                #1;
                chk("arst.do_valid", 32'(s.do_valid), 0);
                chk("arst.busy", 32'(busy), 0);
                chk("arst.cfg_err", 32'(cfg_err), 0);
                chk("arst.ovf", 32'(ovf), 0);
                chk("arst.do_re", 32'(s.do_re), 0);
            end
            tick();
        end
        s.di_en = 1'b0;
        rst = 1'b1;
        tick();

        // Zero config ignores input
        for (int i = 0; i < 3; i++) begin
            s.di_en = 1'b1;
            tick();
        end
        s.di_en = 1'b0;
        chk("zcfg.busy", 32'(busy), 0);
        chk("zcfg.ovf", 32'(ovf), 0);

        // Fresh frame after reset
        load_cfg(4, 3);
        log_q.delete();
        send_frame(600, -1);
        wait_log("post_rst.timeout", 12);
        chk_frame("post_rst", 0, 600);
        chk("post_rst.cfg_err", 32'(cfg_err), 0);
        repeat (3) tick();

        // Mid-frame cfg_load is ignored
        log_q.delete();
        send_frame(700, 5);
        chk("mid.cfg_err", 32'(cfg_err), 1);
        wait_log("mid.timeout", 12);
        chk_frame("mid", 0, 700);
        repeat (3) tick();

`ifdef FFT_REORDER_SCALE_EN
        // Output scaling by 2 with rounding and saturation
        cfg_shift = 2'd2;
        load_cfg(4, 3);
        log_q.delete();
        for (int i = 0; i < 12; i++) begin
            s.di_en = 1'b1;
            s.di_re = 18'h1FFFF;
            s.di_im = 18'h3FFFA;
            tick();
        end
        s.di_en = 1'b0;
        wait_log("scale.timeout", 12);
        chk("scale.sat", (log_q.size() > 0) ? 32'(log_q[0].re) : 32'hFFFFFFFF, 32'h1FFFF);
        chk("scale.neg", (log_q.size() > 0) ? 32'(log_q[0].im) : 32'hFFFFFFFF, 32'h3FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
